// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared constants and types for the SRAM-backed byte FIFO
package sram_fifo_pkg;

    localparam int FIFO_AW   = 10;
    localparam int DEPTH     = 1 << FIFO_AW;
    localparam int RD_LAT    = 1;
    localparam int BUF_DEPTH = 2;

    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [FIFO_AW:0]   cnt_t;
    typedef logic [1:0]         buf_cnt_t;

endpackage

// File: rtl/sram_fifo_prefetch_buf.sv
// rtl/sram_fifo_prefetch_buf.sv - 2-entry registered output buffer fed by SRAM read returns
module sram_fifo_prefetch_buf
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output buf_cnt_t              count
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic                  wr_idx;
    logic                  rd_idx;

    assign head_data = mem[rd_idx];

    // Storage is only zeroed at reset so out_data reads 0 until the first byte lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= '0;
        end else if (clr) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            count <= count + buf_cnt_t'(push) - buf_cnt_t'(pop);
        end
    end

endmodule

// File: rtl/sram_stream_fifo_ctrl.sv
// rtl/sram_stream_fifo_ctrl.sv - byte-stream FIFO over a 1r1w SRAM macro with read prefetch
module sram_stream_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MAC_AW     = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [MAC_AW-1:0]     sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [MAC_AW-1:0]     sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   sram_cnt;
    logic                  rd_inflight;
    buf_cnt_t              buf_cnt;
    logic                  wr_en;
    logic                  rd_en;
    logic                  pop;
    logic                  buf_push;
    logic [2:0]            occupied;
    logic [2:0]            slots_cap;

    assign in_ready  = (sram_cnt != FULL_CNT);
    assign wr_en     = in_valid & in_ready & ~clr;
    assign out_valid = (buf_cnt != '0);
    assign pop       = out_valid & out_ready;

    // A read may issue only if its return is guaranteed a buffer slot; a pop this cycle frees one.
    assign occupied  = {1'b0, buf_cnt} + {2'b00, rd_inflight};
    assign slots_cap = 3'(BUF_DEPTH) + {2'b00, pop};
    assign rd_en     = (sram_cnt != '0) & ~clr & (occupied < slots_cap);
    assign buf_push  = rd_inflight & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            rd_inflight <= 1'b0;
        end else if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            rd_inflight <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            sram_cnt    <= sram_cnt + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(rd_en);
            rd_inflight <= rd_en;
        end
    end

    sram_fifo_prefetch_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (buf_push),
        .push_data (sram_dout1),
        .pop       (pop),
        .head_data (out_data),
        .count     (buf_cnt)
    );

    assign level = (ADDR_WIDTH+2)'(sram_cnt) + (ADDR_WIDTH+2)'(rd_inflight)
                 + (ADDR_WIDTH+2)'(buf_cnt);

    assign sram_csb0  = ~wr_en;
    assign sram_web0  = 1'b0;
    assign sram_addr0 = wr_en ? MAC_AW'(wr_ptr) : '0;
    assign sram_din0  = wr_en ? in_data : '0;
    assign sram_csb1  = ~rd_en;
    assign sram_addr1 = rd_en ? MAC_AW'(rd_ptr) : '0;

endmodule

// File: tb/tb_sram_stream_fifo_ctrl.sv
// tb/tb_sram_stream_fifo_ctrl.sv - directed and random scoreboard bench for sram_stream_fifo_ctrl
module tb_sram_stream_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [11:0] level;
    logic        sram_csb0;
    logic        sram_web0;
    logic [11:0] sram_addr0;
    logic [7:0]  sram_din0;
    logic        sram_csb1;
    logic [11:0] sram_addr1;
    logic [7:0]  sram_dout1;

    int          checks;
    int          errors;
    logic [7:0]  sb [$];
    logic        acc;

    logic [7:0]  mem [0:1023];
    logic        cap_csb0;
    logic        cap_csb1;
    logic [11:0] cap_a0;
    logic [11:0] cap_a1;
    logic [7:0]  cap_d0;
    int          collisions;

    sram_stream_fifo_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: capture at posedge, act at negedge, read data goes X shortly after posedge.
    initial collisions = 0;
    always begin
        @(posedge clk);
        cap_csb0 = sram_csb0;
        cap_csb1 = sram_csb1;
        cap_a0   = sram_addr0;
        cap_a1   = sram_addr1;
        cap_d0   = sram_din0;
        if (!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1) collisions++;
        #1 sram_dout1 = 'x;
        @(negedge clk);
        if (!cap_csb0) mem[cap_a0[9:0]] = cap_d0;
        if (!cap_csb1) sram_dout1 = mem[cap_a1[9:0]];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; inputs held for one full cycle.
    task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #2;
        acc = in_valid && in_ready && !clr;
        if (acc) sb.push_back(d);
        if (out_valid && out_ready) begin
            chk("sb_nonempty_on_pop", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("data", 32'(out_data), 32'(sb.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            cycle(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk({tag, "_drained"}, 32'(sb.size()), 0);
        chk({tag, "_level0"}, 32'(level), 0);
    endtask

    initial begin
        int n;
        int g;
        int dev;
        int maxlvl;
        logic [11:0] lvl_ref;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_csb0", 32'(sram_csb0), 1);
        chk("rst_csb1", 32'(sram_csb1), 1);
        chk("rst_addr0", 32'(sram_addr0), 0);
        chk("rst_addr1", 32'(sram_addr1), 0);
        chk("rst_din0", 32'(sram_din0), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 8'h10), 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_csb0", 32'(sram_csb0), 1);
        chk("midrst_csb1", 32'(sram_csb1), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        cycle(1'b1, 8'hA5, 1'b0);
        drain("midrst");

        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        chk("order_level", 32'(level), 16);
        for (int i = 0; i < 16; i++) begin
            chk("order_out_valid", 32'(out_valid), 1);
            cycle(1'b0, 8'h00, 1'b1);
        end
        chk("order_level0", 32'(level), 0);

        n = 0;
        g = 0;
        while (n < 1026 && g < 1500) begin
            cycle(1'b1, 8'(n), 1'b0);
            if (acc) n++;
            g++;
        end
        chk("full_pushed", 32'(n), 1026);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        chk("full_level", 32'(level), 1026);
        chk("full_in_ready", 32'(in_ready), 0);
        cycle(1'b1, 8'hEE, 1'b0);
        chk("full_level_hold", 32'(level), 1026);
        cycle(1'b0, 8'h00, 1'b1);
        g = 0;
        while (!in_ready && g < 2) begin
            cycle(1'b0, 8'h00, 1'b0);
            g++;
        end
        chk("full_ready_return", 32'(in_ready), 1);
        drain("full");

        dev = 0;
        lvl_ref = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 200) lvl_ref = level;
            if (i > 200 && level != lvl_ref) dev++;
            cycle(1'b1, 8'($urandom), 1'b1);
        end
        chk("stream_level_const", 32'(dev), 0);
        chk("stream_out_valid", 32'(out_valid), 1);
        drain("stream");

        maxlvl = 0;
        for (int i = 0; i < 2000; i++) begin
            if (int'(level) > maxlvl) maxlvl = int'(level);
            cycle(1'(($urandom % 2)), 8'($urandom), 1'(($urandom % 2)));
        end
        chk("rand_level_max", 32'(maxlvl <= 1026), 1);
        drain("rand");

        cycle(1'b1, 8'h77, 1'b0);
        chk("clr_read_issue", 32'(sram_csb1), 0);
        cycle(1'b0, 8'h00, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        #2;
        chk("clr_csb0", 32'(sram_csb0), 1);
        chk("clr_csb1", 32'(sram_csb1), 1);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        chk("clr_out_valid", 32'(out_valid), 0);
        chk("clr_level", 32'(level), 0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("clr_dropped_return", 32'(out_valid), 0);
        cycle(1'b1, 8'h3C, 1'b0);
        drain("clr");

        chk("no_collisions", 32'(collisions), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
